imm_encoder: RTL and testbench

- Inverse of the ALU-B operand mux. It takes a 16-bit constant and emits the shortest sequence of instruction-field beats (ARGA_X, ARGB_X, LDSINCF, ALUB_SRCX) that rebuilds that constant on ALUB_DATA.
- Used by the literal-load path and the microcode/loader, so that constants are encoded with the same field layout the datapath decodes.
- Produces one beat for short constants, or two beats (U8, then U8H) for full 16-bit values.

---
 rtl/imm_encoder.sv | 208 ++++++++++++++++++++
 tb/tb_imm_encoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Turns a 16-bit constant into the shortest sequence of ALU-B
//            operand beats (ARGA_X / ARGB_X / LDSINCF / ALUB_SRCX) that the
//            datapath operand mux decodes back into the same constant.
//            Short constants take one beat; full 16-bit values take a U8 beat
//            followed by a U8H beat that supplies the upper byte.
// Ports    : CLK        - clock, rising edge
//            RESET      - synchronous, active-low reset
//            IMM_DIN    - constant to encode      IMM_VALID - IMM_DIN valid
//            IMM_READY  - encoder idle, takes a constant this cycle
//            ARGA_X     - beat field A            ARGB_X    - beat field B
//            LDSINCF    - bits [5:4] source for U6 / U6_0
//            ALUB_SRCX  - operand mux selector code
//            BEAT_VALID - beat fields valid       BEAT_READY - consumer takes beat
//            BEAT_LAST  - current beat completes the constant
// Revision : 1.0 - initial release
// ============================================================================
module imm_encoder #(
    parameter logic ALLOW_SHIFTED = 1'b1,
    parameter logic ALLOW_S8      = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] IMM_DIN,
    input  logic        IMM_VALID,
    output logic        IMM_READY,
    output logic [3:0]  ARGA_X,
    output logic [3:0]  ARGB_X,
    output logic [1:0]  LDSINCF,
    output logic [2:0]  ALUB_SRCX,
    output logic        BEAT_VALID,
    input  logic        BEAT_READY,
    output logic        BEAT_LAST
);

    // Operand mux selector codes (must match the datapath decode table).
    localparam logic [2:0] c_SRC_U4   = 3'd0;
    localparam logic [2:0] c_SRC_U4_0 = 3'd1;
    localparam logic [2:0] c_SRC_U6   = 3'd2;
    localparam logic [2:0] c_SRC_U6_0 = 3'd3;
    localparam logic [2:0] c_SRC_U8   = 3'd4;
    localparam logic [2:0] c_SRC_S8   = 3'd5;
    localparam logic [2:0] c_SRC_U8H  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT1 = 2'd1,
        S_BEAT2 = 2'd2
    } state_t;

    state_t      r_state, w_state_n;
    logic        r_ready, w_ready_n;
    logic [2:0]  r_src,  w_src_n;
    logic [3:0]  r_arga, w_arga_n;
    logic [3:0]  r_argb, w_argb_n;
    logic [1:0]  r_lds,  w_lds_n;
    logic        r_last, w_last_n;
    logic        r_two,  w_two_n;
    logic [7:0]  r_hi,   w_hi_n;

    // Encoding of IMM_DIN as a first beat
    logic [2:0]  w_enc_src;
    logic [3:0]  w_enc_arga;
    logic [3:0]  w_enc_argb;
    logic [1:0]  w_enc_lds;
    logic        w_enc_two;
    logic        w_even;
    logic        w_xfer;

    assign w_even = ~IMM_DIN[0];
    assign w_xfer = BEAT_VALID & BEAT_READY;

    // Priority chain: first (shortest) encoding that reproduces the value.
    always_comb begin
        w_enc_src  = c_SRC_U8;
        w_enc_arga = 4'h0;
        w_enc_argb = 4'h0;
        w_enc_lds  = 2'b00;
        w_enc_two  = 1'b0;
        if (IMM_DIN < 16'd16) begin
            w_enc_src  = c_SRC_U4;
            w_enc_argb = IMM_DIN[3:0];
        end else if (ALLOW_SHIFTED && w_even && (IMM_DIN < 16'd32)) begin
            w_enc_src  = c_SRC_U4_0;
            w_enc_argb = IMM_DIN[4:1];
        end else if (IMM_DIN < 16'd64) begin
            w_enc_src  = c_SRC_U6;
            w_enc_lds  = IMM_DIN[5:4];
            w_enc_argb = IMM_DIN[3:0];
        end else if (ALLOW_SHIFTED && w_even && (IMM_DIN < 16'd128)) begin
            w_enc_src  = c_SRC_U6_0;
            w_enc_lds  = IMM_DIN[6:5];
            w_enc_argb = IMM_DIN[4:1];
        end else if (IMM_DIN < 16'd256) begin
            w_enc_src  = c_SRC_U8;
            w_enc_arga = IMM_DIN[7:4];
            w_enc_argb = IMM_DIN[3:0];
        end else if (ALLOW_S8 && (IMM_DIN >= 16'hFF80)) begin
            w_enc_src  = c_SRC_S8;
            w_enc_arga = IMM_DIN[7:4];
            w_enc_argb = IMM_DIN[3:0];
        end else begin
            // Low byte via U8 now; U8H later keeps ALUB_DIN[7:0] and adds [15:8].
            w_enc_src  = c_SRC_U8;
            w_enc_arga = IMM_DIN[7:4];
            w_enc_argb = IMM_DIN[3:0];
            w_enc_two  = 1'b1;
        end
    end

    // Next state and next (registered) beat fields.
    always_comb begin
        w_state_n = r_state;
        w_src_n   = r_src;
        w_arga_n  = r_arga;
        w_argb_n  = r_argb;
        w_lds_n   = r_lds;
        w_last_n  = r_last;
        w_two_n   = r_two;
        w_hi_n    = r_hi;
        case (r_state)
            S_IDLE: begin
                // r_ready is low for the first cycle out of reset.
                if (r_ready && IMM_VALID) begin
                    w_state_n = S_BEAT1;
                    w_src_n   = w_enc_src;
                    w_arga_n  = w_enc_arga;
                    w_argb_n  = w_enc_argb;
                    w_lds_n   = w_enc_lds;
                    w_last_n  = ~w_enc_two;
                    w_two_n   = w_enc_two;
                    w_hi_n    = IMM_DIN[15:8];
                end
            end
            S_BEAT1: begin
                if (w_xfer) begin
                    if (r_two) begin
                        w_state_n = S_BEAT2;
                        w_src_n   = c_SRC_U8H;
                        w_arga_n  = r_hi[7:4];
                        w_argb_n  = r_hi[3:0];
                        w_lds_n   = 2'b00;
                        w_last_n  = 1'b1;
                    end else begin
                        w_state_n = S_IDLE;
                        w_src_n   = 3'd0;
                        w_arga_n  = 4'h0;
                        w_argb_n  = 4'h0;
                        w_lds_n   = 2'b00;
                        w_last_n  = 1'b0;
                        w_two_n   = 1'b0;
                    end
                end
            end
            S_BEAT2: begin
                if (w_xfer) begin
                    w_state_n = S_IDLE;
                    w_src_n   = 3'd0;
                    w_arga_n  = 4'h0;
                    w_argb_n  = 4'h0;
                    w_lds_n   = 2'b00;
                    w_last_n  = 1'b0;
                    w_two_n   = 1'b0;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
        w_ready_n = (w_state_n == S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_src   <= 3'd0;
            r_arga  <= 4'h0;
            r_argb  <= 4'h0;
            r_lds   <= 2'b00;
            r_last  <= 1'b0;
            r_two   <= 1'b0;
            r_hi    <= 8'h00;
        end else begin
            r_state <= w_state_n;
            r_ready <= w_ready_n;
            r_src   <= w_src_n;
            r_arga  <= w_arga_n;
            r_argb  <= w_argb_n;
            r_lds   <= w_lds_n;
            r_last  <= w_last_n;
            r_two   <= w_two_n;
            r_hi    <= w_hi_n;
        end
    end

    assign IMM_READY  = r_ready;
    assign BEAT_VALID = (r_state != S_IDLE);
    assign ALUB_SRCX  = r_src;
    assign ARGA_X     = r_arga;
    assign ARGB_X     = r_argb;
    assign LDSINCF    = r_lds;
    assign BEAT_LAST  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_encoder
// Purpose  : Directed, table-driven bench for imm_encoder. Instance 0 has all
//            encodings enabled, instance 1 has shifted and S8 forms disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    localparam logic [2:0] c_U4   = 3'd0;
    localparam logic [2:0] c_U4_0 = 3'd1;
    localparam logic [2:0] c_U6   = 3'd2;
    localparam logic [2:0] c_U6_0 = 3'd3;
    localparam logic [2:0] c_U8   = 3'd4;
    localparam logic [2:0] c_S8   = 3'd5;
    localparam logic [2:0] c_U8H  = 3'd6;

    logic        CLK = 1'b0;
    logic        rstn;
    logic [15:0] din   [2];
    logic        vld   [2];
    logic        rdy   [2];
    logic        iready[2];
    logic [3:0]  arga  [2];
    logic [3:0]  argb  [2];
    logic [1:0]  lds   [2];
    logic [2:0]  src   [2];
    logic        bvalid[2];
    logic        blast [2];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    imm_encoder #(.ALLOW_SHIFTED(1'b1), .ALLOW_S8(1'b1)) u_full (
        .CLK(CLK), .RESET(rstn), .IMM_DIN(din[0]), .IMM_VALID(vld[0]),
        .IMM_READY(iready[0]), .ARGA_X(arga[0]), .ARGB_X(argb[0]),
        .LDSINCF(lds[0]), .ALUB_SRCX(src[0]), .BEAT_VALID(bvalid[0]),
        .BEAT_READY(rdy[0]), .BEAT_LAST(blast[0])
    );

    imm_encoder #(.ALLOW_SHIFTED(1'b0), .ALLOW_S8(1'b0)) u_plain (
        .CLK(CLK), .RESET(rstn), .IMM_DIN(din[1]), .IMM_VALID(vld[1]),
        .IMM_READY(iready[1]), .ARGA_X(arga[1]), .ARGB_X(argb[1]),
        .LDSINCF(lds[1]), .ALUB_SRCX(src[1]), .BEAT_VALID(bvalid[1]),
        .BEAT_READY(rdy[1]), .BEAT_LAST(blast[1])
    );

    typedef struct {
        int          sel;
        logic [15:0] v;
        logic        two;
        logic [2:0]  src1;
        logic [3:0]  a1;
        logic [3:0]  b1;
        logic [1:0]  l1;
        logic [3:0]  a2;
        logic [3:0]  b2;
    } vec_t;

    vec_t vecs[$];

    // Observed word: {valid, imm_ready, last, src, arga, argb, lds}
    function automatic logic [15:0] obs(input int s);
        return {bvalid[s], iready[s], blast[s], src[s], arga[s], argb[s], lds[s]};
    endfunction

    function automatic logic [15:0] mk(input logic v, input logic r, input logic l,
                                       input logic [2:0] sc, input logic [3:0] a,
                                       input logic [3:0] b, input logic [1:0] ld);
        return {v, r, l, sc, a, b, ld};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h (v,r,last,src,a,b,l) expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int sel, input logic [15:0] v, input logic two,
                       input logic [2:0] s1, input logic [3:0] a1, input logic [3:0] b1,
                       input logic [1:0] l1, input logic [3:0] a2, input logic [3:0] b2);
        vec_t t;
        t.sel = sel; t.v = v; t.two = two; t.src1 = s1;
        t.a1 = a1; t.b1 = b1; t.l1 = l1; t.a2 = a2; t.b2 = b2;
        vecs.push_back(t);
    endtask

    task automatic wait_ready(input int s);
        int n = 0;
        while (iready[s] !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (iready[s] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: IMM_READY=%b required 1", iready[s]);
        end
    endtask

    // Offer V, then take each beat with BEAT_READY=1 and check it.
    task automatic run_vec(input vec_t t);
        int s = t.sel;
        wait_ready(s);
        din[s] = t.v;
        vld[s] = 1'b1;
        @(negedge CLK);
        vld[s] = 1'b0;
        chk($sformatf("beat1_%h_u%0d", t.v, s), obs(s),
            mk(1'b1, 1'b0, ~t.two, t.src1, t.a1, t.b1, t.l1));
        rdy[s] = 1'b1;
        @(negedge CLK);
        rdy[s] = 1'b0;
        if (t.two) begin
            chk($sformatf("beat2_%h_u%0d", t.v, s), obs(s),
                mk(1'b1, 1'b0, 1'b1, c_U8H, t.a2, t.b2, 2'b00));
            rdy[s] = 1'b1;
            @(negedge CLK);
            rdy[s] = 1'b0;
        end
        chk($sformatf("idle_%h_u%0d", t.v, s), obs(s),
            mk(1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 2'b00));
    endtask

    initial begin
        vec_t t;
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din[i] = 16'h0000;
            vld[i] = 1'b1;
            rdy[i] = 1'b0;
        end

        //   sel  value     two   src1    a1    b1    l1     a2    b2
        add(0, 16'h0007, 1'b0, c_U4,   4'h0, 4'h7, 2'b00, 4'h0, 4'h0);
        add(0, 16'h0000, 1'b0, c_U4,   4'h0, 4'h0, 2'b00, 4'h0, 4'h0);
        add(0, 16'h0016, 1'b0, c_U4_0, 4'h0, 4'hB, 2'b00, 4'h0, 4'h0);
        add(1, 16'h0016, 1'b0, c_U6,   4'h0, 4'h6, 2'b01, 4'h0, 4'h0);
        add(0, 16'h0035, 1'b0, c_U6,   4'h0, 4'h5, 2'b11, 4'h0, 4'h0);
        add(0, 16'h0054, 1'b0, c_U6_0, 4'h0, 4'hA, 2'b10, 4'h0, 4'h0);
        add(1, 16'h0054, 1'b0, c_U8,   4'h5, 4'h4, 2'b00, 4'h0, 4'h0);
        add(0, 16'h007E, 1'b0, c_U6_0, 4'h0, 4'hF, 2'b11, 4'h0, 4'h0);
        add(0, 16'h007F, 1'b0, c_U8,   4'h7, 4'hF, 2'b00, 4'h0, 4'h0);
        add(0, 16'h00FF, 1'b0, c_U8,   4'hF, 4'hF, 2'b00, 4'h0, 4'h0);
        add(0, 16'h00C3, 1'b0, c_U8,   4'hC, 4'h3, 2'b00, 4'h0, 4'h0);
        add(0, 16'hFF81, 1'b0, c_S8,   4'h8, 4'h1, 2'b00, 4'h0, 4'h0);
        add(0, 16'hFF80, 1'b0, c_S8,   4'h8, 4'h0, 2'b00, 4'h0, 4'h0);
        add(1, 16'hFF80, 1'b1, c_U8,   4'h8, 4'h0, 2'b00, 4'hF, 4'hF);
        add(0, 16'hFF7F, 1'b1, c_U8,   4'h7, 4'hF, 2'b00, 4'hF, 4'hF);
        add(0, 16'h0100, 1'b1, c_U8,   4'h0, 4'h0, 2'b00, 4'h0, 4'h1);
        add(1, 16'hFFFF, 1'b1, c_U8,   4'hF, 4'hF, 2'b00, 4'hF, 4'hF);

        // Reset held with IMM_VALID asserted: everything stays 0.
        repeat (2) @(negedge CLK);
        chk("reset_u0", obs(0), 16'h0000);
        chk("reset_u1", obs(1), 16'h0000);
        rstn   = 1'b1;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        @(negedge CLK);
        chk("release_u0", obs(0), mk(1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 2'b00));
        chk("release_u1", obs(1), mk(1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 2'b00));

        foreach (vecs[i]) run_vec(vecs[i]);

        // 0xA534 with a 3-cycle stall on each beat.
        wait_ready(0);
        din[0] = 16'hA534;
        vld[0] = 1'b1;
        @(negedge CLK);
        vld[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall1_%0d", i), obs(0),
                mk(1'b1, 1'b0, 1'b0, c_U8, 4'h3, 4'h4, 2'b00));
            @(negedge CLK);
        end
        chk("stall1_end", obs(0), mk(1'b1, 1'b0, 1'b0, c_U8, 4'h3, 4'h4, 2'b00));
        rdy[0] = 1'b1;
        @(negedge CLK);
        rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall2_%0d", i), obs(0),
                mk(1'b1, 1'b0, 1'b1, c_U8H, 4'hA, 4'h5, 2'b00));
            @(negedge CLK);
        end
        chk("stall2_end", obs(0), mk(1'b1, 1'b0, 1'b1, c_U8H, 4'hA, 4'h5, 2'b00));
        rdy[0] = 1'b1;
        @(negedge CLK);
        rdy[0] = 1'b0;
        chk("stall_idle", obs(0), mk(1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 2'b00));

        // Reset during BEAT2 of 0x1234 drops the beat.
        wait_ready(0);
        din[0] = 16'h1234;
        vld[0] = 1'b1;
        @(negedge CLK);
        vld[0] = 1'b0;
        chk("rst_beat1", obs(0), mk(1'b1, 1'b0, 1'b0, c_U8, 4'h3, 4'h4, 2'b00));
        rdy[0] = 1'b1;
        @(negedge CLK);
        rdy[0] = 1'b0;
        chk("rst_beat2", obs(0), mk(1'b1, 1'b0, 1'b1, c_U8H, 4'h1, 4'h2, 2'b00));
        rstn = 1'b0;
        @(negedge CLK);
        chk("rst_in_beat2", obs(0), 16'h0000);
        rstn = 1'b1;
        @(negedge CLK);
        chk("rst_release", obs(0), mk(1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 2'b00));
        t.sel = 0; t.v = 16'h000F; t.two = 1'b0; t.src1 = c_U4;
        t.a1 = 4'h0; t.b1 = 4'hF; t.l1 = 2'b00; t.a2 = 4'h0; t.b2 = 4'h0;
        run_vec(t);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
